keypad_entry: RTL and testbench
===============================

# keypad_entry

Parametrised 4x4 keypad front end that scans rows, debounces press and release, and accumulates accepted keys into a multi-digit entry buffer. It drives the keypad rows and reads its columns directly. Its `digits` bus feeds the seven/fourteen-segment scan multiplexer one nibble per digit, so N keys typed in sequence scroll across the display. It supersedes single-key scanning, which kept only the last key, had no debounce and no release detection.

## Interface
- `DIGITS`, 4: number of 4-bit entries in the buffer (1..8).
- `DEBOUNCE`, 4: consecutive stable scan cycles required to accept a press or a release (2..15).
- `clk`  in  1  scan clock (the divided ~150 Hz scan clock); all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `col_n`  in  4  keypad columns, active low, sampled directly each edge; the slow clock guarantees settling.
- `row_n`  out  4  row drive, one-hot active low.
- `pressed`  out  1  high while a debounced key is held.
- `key_valid`  out  1  one-cycle strobe for each accepted key.
- `key_code`  out  4  code of the last accepted key, computed as 4*row_index + col_index.
- `digits`  out  4*DIGITS  entry buffer; nibble 0 (LSB) holds the newest key.

## Operation
- Reset values:
  - `row_n`=4'b1110 (row 0).
  - `pressed`=0, `key_valid`=0, `key_code`=0.
  - Every `digits` nibble = 4'hF (blank).
  - FSM in SCAN; all counters 0.
- Row index r corresponds to `row_n` bit r low. Column index c corresponds to `col_n` bit c low. If several columns are low, the lowest c wins.
- SCAN:
  - If `col_n`==4'hF, rotate to the next row (1110->1101->1011->0111->1110).
  - Otherwise latch r and the `col_n` pattern, hold the row, set cnt=1 and go to DEBOUNCE.
- DEBOUNCE:
  - If `col_n` equals the latched pattern, increment cnt.
  - When cnt reaches DEBOUNCE-1 with a match: go to HELD, set `pressed`=1, pulse `key_valid`, load `key_code`, and update the buffer.
  - On any mismatch: no key is accepted; return to SCAN and advance the row on the same edge.
- HELD:
  - The row stays held and rcnt counts consecutive edges with `col_n`==4'hF.
  - Any low column resets rcnt to 0.
  - When rcnt reaches DEBOUNCE: go to SCAN, set `pressed`=0, and resume scanning from the next row.
  - A change of key while held is ignored until a full release.
- Buffer update: shift left by one nibble, new key into nibble 0, oldest nibble dropped. No full flag; the buffer wraps by discarding.
- Reset mid-operation (any state) forces all reset values immediately. No `key_valid` is produced for a press in progress.

## Timing
- Detection edge t0 (SCAN sees a low column).
- The edges t0+1 .. t0+DEBOUNCE-1 must all match.
- `key_valid`, `key_code` and `digits` update on edge t0+DEBOUNCE-1. `key_valid` is high for exactly one cycle.
- Release: `pressed` falls on the DEBOUNCE-th consecutive all-high edge. `row_n` advances on the following edge.
- Minimum interval between two accepted keys: 2*DEBOUNCE cycles.
- All outputs are registered; none is combinational from `col_n`.

## Configuration
- `KEYPAD_ENTRY_CLEAR_EN` defined:
  - Key code 4'hF does not shift.
  - On its accept edge all `digits` nibbles become 4'hF.
  - `key_valid` still pulses with `key_code`=4'hF.
- Undefined: 4'hF is shifted in like any other key (displays as blank).

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0, then release with `col_n`=4'hF.
  - Required: `digits`=16'hFFFF, `pressed`=0, and `row_n` cycles 1110,1101,1011,0111,1110 on consecutive edges.
- Clean press:
  - Stimulus: hold row 1 / col 2 low (`col_n`=4'b1011 whenever `row_n`=4'b1101) for 10 cycles, then release.
  - Required: one `key_valid` with `key_code`=6, exactly 3 edges after detection; `digits`=16'hFFF6; `pressed` falls after 4 high samples.
- Bounce:
  - Stimulus: key low for 2 edges, high for 1, then low steadily.
  - Required: no `key_valid` for the first burst; exactly one `key_valid` after the stable run.
- Sequence:
  - Stimulus: press and release keys 1, 2, 3, 4, 5 in order.
  - Required: `digits`=16'h2345 after the fifth accept; exactly 5 strobes.
- Clear:
  - Stimulus: after the Sequence scenario, press key 15 (row 3 / col 3).
  - Required with `KEYPAD_ENTRY_CLEAR_EN`: `digits`=16'hFFFF. Required without it: `digits`=16'h345F.
- Reset mid-press:
  - Stimulus: assert `rst_n`=0 during DEBOUNCE.
  - Required: immediate reset values and no `key_valid`.

Source files
------------

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with press/release debounce and a shifting multi-digit entry buffer.
// Optional build macro KEYPAD_ENTRY_CLEAR_EN: key 4'hF blanks the whole buffer instead of shifting in.
module keypad_entry #(
   parameter int DIGITS   = 4,
   parameter int DEBOUNCE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            col_n,
   output logic [3:0]            row_n,
   output logic                  pressed,
   output logic                  key_valid,
   output logic [3:0]            key_code,
   output logic [4*DIGITS-1:0]   digits
);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD
   } state_t;

   localparam logic [3:0] LP_PRESS_LAST = 4'(DEBOUNCE - 1);
   localparam logic [3:0] LP_REL_LAST   = 4'(DEBOUNCE - 1);

   state_t                r_state,    w_state;
   logic [3:0]            r_row,      w_row;
   logic [1:0]            r_rowIdx,   w_rowIdx;
   logic [3:0]            r_pattern,  w_pattern;
   logic [3:0]            r_cnt,      w_cnt;
   logic [3:0]            r_rcnt,     w_rcnt;
   logic                  r_pressed,  w_pressed;
   logic                  r_keyValid, w_keyValid;
   logic [3:0]            r_keyCode,  w_keyCode;
   logic [4*DIGITS-1:0]   r_digits,   w_digits;

   logic [1:0]            w_colIdx;
   logic [3:0]            w_code;
   logic [4*DIGITS-1:0]   w_shifted;
   logic [4*DIGITS-1:0]   w_bufNext;

   // Lowest low column of the latched pattern wins when several keys share a row.
   always_comb begin
      w_colIdx = 2'd3;
      if (!r_pattern[0])      w_colIdx = 2'd0;
      else if (!r_pattern[1]) w_colIdx = 2'd1;
      else if (!r_pattern[2]) w_colIdx = 2'd2;
      w_code = {r_rowIdx, w_colIdx};
   end

   always_comb begin
      w_shifted       = r_digits << 4;
      w_shifted[3:0]  = w_code;
`ifdef KEYPAD_ENTRY_CLEAR_EN
      if (w_code == 4'hF) w_bufNext = '1;
      else                w_bufNext = w_shifted;
`else
      w_bufNext = w_shifted;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_SCAN;
         r_row      <= 4'b1110;
         r_rowIdx   <= 2'd0;
         r_pattern  <= 4'hF;
         r_cnt      <= 4'd0;
         r_rcnt     <= 4'd0;
         r_pressed  <= 1'b0;
         r_keyValid <= 1'b0;
         r_keyCode  <= 4'd0;
         r_digits   <= '1;
      end else begin
         r_state    <= w_state;
         r_row      <= w_row;
         r_rowIdx   <= w_rowIdx;
         r_pattern  <= w_pattern;
         r_cnt      <= w_cnt;
         r_rcnt     <= w_rcnt;
         r_pressed  <= w_pressed;
         r_keyValid <= w_keyValid;
         r_keyCode  <= w_keyCode;
         r_digits   <= w_digits;
      end
   end

   // The press counter starts at 1 on the detection edge, so the accept edge is the
   // one where the counter already holds DEBOUNCE-1 and the columns still match.
   always_comb begin
      w_state    = r_state;
      w_row      = r_row;
      w_rowIdx   = r_rowIdx;
      w_pattern  = r_pattern;
      w_cnt      = r_cnt;
      w_rcnt     = r_rcnt;
      w_pressed  = r_pressed;
      w_keyValid = 1'b0;
      w_keyCode  = r_keyCode;
      w_digits   = r_digits;
      case (r_state)
         ST_SCAN: begin
            if (col_n == 4'hF) begin
               w_row    = {r_row[2:0], r_row[3]};
               w_rowIdx = r_rowIdx + 2'd1;
            end else begin
               w_pattern = col_n;
               w_cnt     = 4'd1;
               w_state   = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (col_n == r_pattern) begin
               if (r_cnt == LP_PRESS_LAST) begin
                  w_state    = ST_HELD;
                  w_pressed  = 1'b1;
                  w_keyValid = 1'b1;
                  w_keyCode  = w_code;
                  w_digits   = w_bufNext;
                  w_rcnt     = 4'd0;
                  w_cnt      = 4'd0;
               end else begin
                  w_cnt = r_cnt + 4'd1;
               end
            end else begin
               w_state  = ST_SCAN;
               w_cnt    = 4'd0;
               w_row    = {r_row[2:0], r_row[3]};
               w_rowIdx = r_rowIdx + 2'd1;
            end
         end
         ST_HELD: begin
            if (col_n == 4'hF) begin
               if (r_rcnt == LP_REL_LAST) begin
                  w_state   = ST_SCAN;
                  w_pressed = 1'b0;
                  w_rcnt    = 4'd0;
               end else begin
                  w_rcnt = r_rcnt + 4'd1;
               end
            end else begin
               w_rcnt = 4'd0;
            end
         end
         default: begin
            w_state = ST_SCAN;
         end
      endcase
   end

   assign row_n     = r_row;
   assign pressed   = r_pressed;
   assign key_valid = r_keyValid;
   assign key_code  = r_keyCode;
   assign digits    = r_digits;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a keypad model drives the columns from the row drive,
// and an abstract cycle model predicts every output; literal checks pin the key scenarios.
module tb_keypad_entry;

   localparam int D    = 4;
   localparam int NDIG = 4;

   logic                clk;
   logic                rst_n;
   logic [3:0]          col_n;
   logic [3:0]          row_n;
   logic                pressed;
   logic                key_valid;
   logic [3:0]          key_code;
   logic [4*NDIG-1:0]   digits;

   logic                keyDown;
   logic [1:0]          keyRow;
   logic [1:0]          keyCol;
   logic [3:0]          sampledCol;
   logic                rstSample;
   int                  validCount;
   int                  checkCount;
   int                  passCount;

   int                  mCyc;
   int                  mMode;
   int                  mRow;
   int                  mT0;
   int                  mHigh;
   logic [3:0]          mPat;
   logic                mValid;
   logic                mPressed;
   logic [3:0]          mCode;
   int                  q[$];

   keypad_entry #(.DIGITS(NDIG), .DEBOUNCE(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_n     (col_n),
      .row_n     (row_n),
      .pressed   (pressed),
      .key_valid (key_valid),
      .key_code  (key_code),
      .digits    (digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] colPattern(input logic [1:0] c);
      logic [3:0] p;
      p    = 4'hF;
      p[c] = 1'b0;
      return p;
   endfunction

   // The physical keypad: a held key pulls its column low only while its row is driven.
   assign col_n = (keyDown && (row_n[keyRow] == 1'b0)) ? colPattern(keyCol) : 4'hF;

   always @(posedge clk) begin
      sampledCol <= col_n;
      rstSample  <= rst_n;
   end

   always @(negedge clk) begin
      if (key_valid) validCount <= validCount + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
   endtask

   task automatic failTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: timed out waiting for the design at %0t", name, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Abstract model: scan position, a press window timed by cycle distance from detection,
   // a release run length, and the entry buffer as a queue of key codes (front = newest).
   task automatic modelReset();
      mCyc     = 0;
      mMode    = 0;
      mRow     = 0;
      mT0      = 0;
      mHigh    = 0;
      mPat     = 4'hF;
      mValid   = 1'b0;
      mPressed = 1'b0;
      mCode    = 4'd0;
      q.delete();
      for (int i = 0; i < NDIG; i++) q.push_back(15);
   endtask

   task automatic modelAccept(input logic [3:0] pat);
      int c;
      int code;
      c = 3;
      for (int i = 3; i >= 0; i--) if (pat[i] == 1'b0) c = i;
      code     = mRow * 4 + c;
      mValid   = 1'b1;
      mPressed = 1'b1;
      mCode    = 4'(code);
`ifdef KEYPAD_ENTRY_CLEAR_EN
      if (code == 15) begin
         for (int i = 0; i < NDIG; i++) q[i] = 15;
      end else begin
         q.push_front(code);
         void'(q.pop_back());
      end
`else
      q.push_front(code);
      void'(q.pop_back());
`endif
   endtask

   task automatic modelStep(input logic [3:0] col);
      mCyc++;
      mValid = 1'b0;
      if (mMode == 0) begin
         if (col == 4'hF) mRow = (mRow + 1) % 4;
         else begin
            mMode = 1;
            mT0   = mCyc;
            mPat  = col;
         end
      end else if (mMode == 1) begin
         if (col != mPat) begin
            mMode = 0;
            mRow  = (mRow + 1) % 4;
         end else if (mCyc - mT0 == D - 1) begin
            modelAccept(col);
            mMode = 2;
            mHigh = 0;
         end
      end else begin
         if (col == 4'hF) mHigh++;
         else mHigh = 0;
         if (mHigh == D) begin
            mMode    = 0;
            mPressed = 1'b0;
         end
      end
   endtask

   initial begin
      logic [4*NDIG-1:0] expDigits;
      logic [3:0]        expRow;
      modelReset();
      forever begin
         @(negedge clk);
         if (!rst_n || !rstSample) begin
            modelReset();
         end else begin
            modelStep(sampledCol);
            expRow = 4'hF;
            expRow[mRow] = 1'b0;
            for (int i = 0; i < NDIG; i++) expDigits[4*i +: 4] = 4'(q[i]);
            checkOutput("model_row_n",     32'(row_n),     32'(expRow));
            checkOutput("model_pressed",   32'(pressed),   32'(mPressed));
            checkOutput("model_key_valid", 32'(key_valid), 32'(mValid));
            checkOutput("model_key_code",  32'(key_code),  32'(mCode));
            checkOutput("model_digits",    32'(digits),    32'(expDigits));
         end
      end
   end

   // Press one key, optionally aligned so the hold begins just before its row is scanned;
   // reports edges from press to strobe and from release to the fall of pressed.
   task automatic applyStimulus(input logic [1:0] r, input logic [1:0] c, input bit align,
                                input int hold, output int lat, output int rel);
      int n;
      lat     = -1;
      rel     = -1;
      keyRow  = r;
      keyCol  = c;
      if (align) begin
         n = 0;
         while (row_n[r] != 1'b0 && n < 8) begin
            tick();
            n++;
         end
         if (row_n[r] != 1'b0) failTimeout("align_row");
      end
      keyDown = 1'b1;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (key_valid) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) failTimeout("wait_key_valid");
      repeat (hold) tick();
      keyDown = 1'b0;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (!pressed) begin
            rel = n;
            break;
         end
      end
      if (rel < 0) failTimeout("wait_release");
      tick();
   endtask

   initial begin
      logic [3:0] rowSeq [5];
      logic [1:0] seqRow [5];
      logic [1:0] seqCol [5];
      int         lat;
      int         rel;
      int         vc0;
      int         n;

      rowSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      seqRow = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
      seqCol = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      checkCount = 0;
      passCount  = 0;
      validCount = 0;
      keyDown    = 1'b0;
      keyRow     = 2'd0;
      keyCol     = 2'd0;
      rst_n      = 1'b0;

      $display("[TB] reset");
      repeat (3) tick();
      checkOutput("reset_digits",    32'(digits),    32'h0000FFFF);
      checkOutput("reset_pressed",   32'(pressed),   32'd0);
      checkOutput("reset_key_valid", 32'(key_valid), 32'd0);
      checkOutput("reset_key_code",  32'(key_code),  32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("reset_row_cycle", 32'(row_n), 32'(rowSeq[i]));
         if (i < 4) tick();
      end

      $display("[TB] clean press");
      vc0 = validCount;
      applyStimulus(2'd1, 2'd2, 1'b1, 10, lat, rel);
      checkOutput("clean_latency", 32'(lat), 32'd4);
      checkOutput("clean_key_code", 32'(key_code), 32'd6);
      checkOutput("clean_digits", 32'(digits), 32'h0000FFF6);
      checkOutput("clean_release", 32'(rel), 32'd4);
      checkOutput("clean_strobes", 32'(validCount - vc0), 32'd1);

      $display("[TB] bounce");
      vc0    = validCount;
      keyRow = 2'd2;
      keyCol = 2'd0;
      n = 0;
      while (row_n[2] != 1'b0 && n < 8) begin
         tick();
         n++;
      end
      if (row_n[2] != 1'b0) failTimeout("bounce_align");
      keyDown = 1'b1;
      tick();
      tick();
      keyDown = 1'b0;
      tick();
      checkOutput("bounce_no_strobe", 32'(validCount - vc0), 32'd0);
      applyStimulus(2'd2, 2'd0, 1'b0, 2, lat, rel);
      checkOutput("bounce_strobes", 32'(validCount - vc0), 32'd1);
      checkOutput("bounce_digits", 32'(digits), 32'h0000FF68);

      $display("[TB] sequence");
      vc0 = validCount;
      for (int i = 0; i < 5; i++) applyStimulus(seqRow[i], seqCol[i], 1'b0, 1, lat, rel);
      checkOutput("seq_strobes", 32'(validCount - vc0), 32'd5);
      checkOutput("seq_digits", 32'(digits), 32'h00002345);
      checkOutput("seq_key_code", 32'(key_code), 32'd5);

      $display("[TB] clear key");
      applyStimulus(2'd3, 2'd3, 1'b0, 1, lat, rel);
      checkOutput("clear_key_code", 32'(key_code), 32'hF);
`ifdef KEYPAD_ENTRY_CLEAR_EN
      checkOutput("clear_digits", 32'(digits), 32'h0000FFFF);
`else
      checkOutput("clear_digits", 32'(digits), 32'h0000345F);
`endif

      $display("[TB] reset mid-press");
      vc0    = validCount;
      keyRow = 2'd0;
      keyCol = 2'd0;
      n = 0;
      while (row_n[0] != 1'b0 && n < 8) begin
         tick();
         n++;
      end
      if (row_n[0] != 1'b0) failTimeout("midreset_align");
      keyDown = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_row_n",     32'(row_n),     32'h0000000E);
      checkOutput("midreset_pressed",   32'(pressed),   32'd0);
      checkOutput("midreset_key_valid", 32'(key_valid), 32'd0);
      checkOutput("midreset_key_code",  32'(key_code),  32'd0);
      checkOutput("midreset_digits",    32'(digits),    32'h0000FFFF);
      keyDown = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      checkOutput("midreset_no_strobe", 32'(validCount - vc0), 32'd0);
      checkOutput("midreset_after_digits", 32'(digits), 32'h0000FFFF);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
